// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N requesters.
// One access per grant: IDLE -> ISSUE -> WAIT -> ACK, all outputs registered.
module mem_bus_arbiter #(
  parameter int N       = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr,
  input  logic [N*DW-1:0] wdata,
  output logic [N-1:0]    ack,
  output logic [DW-1:0]   rdata,
  output logic [N-1:0]    grant,
  output logic            busy,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [PW:0]   NN     = (PW+1)'(N);
  localparam logic [PW-1:0] LAST   = PW'(N-1);
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LAT-1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [CW-1:0] cnt;
  logic [PW-1:0] win;
  logic          found;
  logic [PW:0]   scan;

  // Scan upward from the pointer, wrapping at N; first requester wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    scan  = '0;
    for (int j = 0; j < N; j++) begin
      scan = {1'b0, ptr} + (PW+1)'(j);
      if (scan >= NN)
        scan = scan - NN;
      if (!found && req[scan[PW-1:0]]) begin
        win   = scan[PW-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            owner     <= win;
            grant     <= N'(1) << win;
            mem_addr  <= addr[int'(win)*AW +: AW];
            mem_we    <= we[win];
            mem_wdata <= wdata[int'(win)*DW +: DW];
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          cnt    <= LAT_M1;
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == '0) begin
            rdata <= mem_we ? '0 : mem_rdata;
            ack   <= grant;
            state <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          ack   <= '0;
          grant <= '0;
          busy  <= 1'b0;
          rdata <= '0;
          ptr   <= (owner == LAST) ? '0 : owner + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed steps then random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int L  = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req, we, ack, grant;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0]   rdata, mem_rdata, mem_wdata;
  logic            busy, mem_en, mem_we;
  logic [AW-1:0]   mem_addr;

  mem_bus_arbiter #(.N(N), .AW(AW), .DW(DW), .MEM_LAT(L)) dut (
    .clock(clock), .reset(reset), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata),
    .grant(grant), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 16) ? 32'hDEADBEEF : 32'h1000_0000 + a * 32'h0101_0101;
  endfunction

  // Memory with fixed read latency L from the mem_en cycle
  bit [DW-1:0] mem [64];
  bit          written [64];
  bit [DW-1:0] pipe [L];
  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[5:0]]     <= mem_wdata;
      written[mem_addr[5:0]] <= 1'b1;
    end
    if (mem_en)
      pipe[0] <= written[mem_addr[5:0]] ? mem[mem_addr[5:0]] : init_val(int'(mem_addr[5:0]));
    else
      pipe[0] <= '0;
    for (int i = 1; i < L; i++)
      pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[L-1];

  int            vectors = 0;
  int            errors  = 0;
  int            tcur, k, w, ptr, pend;
  bit            act, rereq, rnd;
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_rd, m_wdata;
  logic [AW-1:0] m_addr;
  logic          m_we;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s t=%0d observed=%h expected=%h", tag, tcur, got, exp);
    end
  endtask

  task automatic new_attr(input int i);
    we[i]               = 1'($urandom_range(0, 1));
    addr[i*AW +: AW]    = AW'($urandom_range(0, 63));
    wdata[i*DW +: DW]   = $urandom;
  endtask

  task automatic tick(input bit rst);
    logic [N-1:0] eg, ea;
    bit           in_txn;
    int           idx;
    if (pend >= 0) begin
      if (rereq) new_attr(pend);
      else req[pend] = 1'b0;
      pend = -1;
    end
    if (rnd) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && $urandom_range(0, 4) == 0) begin
          new_attr(i);
          req[i] = 1'b1;
        end
      if (act && tcur > k + 1 && tcur < k + 2 + L) begin
        if ($urandom_range(0, 9) == 0) req[w] = 1'b0;
        if ($urandom_range(0, 4) == 0) new_attr(w);
      end
    end
    reset = rst;
    // Reference model decides on this cycle's inputs
    if (rst) begin
      act = 0; ptr = 0;
      m_addr = '0; m_we = 1'b0; m_wdata = '0;
    end else begin
      if (act && tcur == k + 2 + L) ptr = (w + 1) % N;
      if ((!act || tcur >= k + 3 + L) && req != '0) begin
        for (int j = N - 1; j >= 0; j--) begin
          idx = (ptr + j) % N;
          if (req[idx]) w = idx;
        end
        act = 1; k = tcur;
        m_addr  = addr[w*AW +: AW];
        m_we    = we[w];
        m_wdata = wdata[w*DW +: DW];
        if (m_we) begin
          ref_mem[m_addr[5:0]] = m_wdata;
          exp_rd = '0;
        end else begin
          exp_rd = ref_mem[m_addr[5:0]];
        end
      end
    end
    @(posedge clock);
    #1;
    tcur++;
    in_txn = act && tcur >= k + 1 && tcur <= k + 2 + L;
    eg = in_txn ? N'(1) << w : '0;
    ea = (act && tcur == k + 2 + L) ? N'(1) << w : '0;
    chk("grant", 64'(grant), 64'(eg));
    chk("busy", 64'(busy), 64'(in_txn));
    chk("mem_en", 64'(mem_en), 64'(act && tcur == k + 1));
    chk("ack", 64'(ack), 64'(ea));
    chk("rdata", 64'(rdata), (ea != '0) ? 64'(exp_rd) : 64'd0);
    chk("mem_addr", 64'(mem_addr), 64'(m_addr));
    chk("mem_we", 64'(mem_we), 64'(m_we));
    chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
    if (ea != '0) pend = w;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    req = '0; we = '0; addr = '0; wdata = '0; reset = 1'b1;
    tcur = 0; k = 0; w = 0; ptr = 0; pend = -1;
    act = 0; rereq = 0; rnd = 0;
    exp_rd = '0; m_addr = '0; m_we = 1'b0; m_wdata = '0;

    tick(1); tick(1);

    // Single read from requester 0
    we[0] = 1'b0; addr[0 +: AW] = 32'h10; req[0] = 1'b1;
    repeat (6) tick(0);

    // Single write from requester 1
    we[1] = 1'b1; addr[AW +: AW] = 32'h20;
    wdata[DW +: DW] = 32'h12345678; req[1] = 1'b1;
    repeat (6) tick(0);

    // Contention between 0 and 1, both re-request after ack
    rereq = 1;
    new_attr(0); new_attr(1); req[1:0] = 2'b11;
    repeat (25) tick(0);
    rereq = 0; req = '0;
    repeat (6) tick(0);

    // Reset during WAIT, then requester 1 alone, then 0 and 1 together
    new_attr(1); req[1] = 1'b1;
    repeat (3) tick(0);
    tick(1);
    repeat (6) tick(0);
    tick(1);
    new_attr(0); req[1:0] = 2'b11;
    repeat (6) tick(0);
    req = '0;
    repeat (6) tick(0);

    // Fairness: 0 requests continuously, 3 joins
    rereq = 1;
    new_attr(0); req[0] = 1'b1;
    repeat (4) tick(0);
    new_attr(3); req[3] = 1'b1;
    repeat (15) tick(0);
    rereq = 0; req = '0;
    repeat (6) tick(0);

    // Withdrawal of the granted request during WAIT
    new_attr(0); new_attr(1); req[1:0] = 2'b11;
    repeat (3) tick(0);
    req[w] = 1'b0;
    repeat (10) tick(0);
    req = '0;
    repeat (6) tick(0);

    // Random traffic with occasional reset
    rnd = 1;
    repeat (3000) tick($urandom_range(0, 99) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port instruction/data memory between N requesters (CPU fetch, CPU store, loader/DMA).
- Each requester uses a req/ack handshake. The arbiter grants one requester at a time, issues one memory access, waits a fixed memory latency, then returns read data with a one-cycle ack.
- Grants are round-robin, so no requester starves.
- Sits between the requesters and the memory port; owns mem_en/mem_we/mem_addr/mem_wdata exclusively.

Parameters:
- N, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to the cycle in which mem_rdata is valid (>=1).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N  per-requester request level; held high until ack.
- we  in  N  per-requester write enable; 1 = write, 0 = read.
- addr  in  N*AW  per-requester address; requester i occupies bits [i*AW +: AW].
- wdata  in  N*DW  per-requester write data; requester i occupies bits [i*DW +: DW].
- ack  out  N  one-hot, one-cycle completion pulse.
- rdata  out  DW  read data, valid only while ack is nonzero.
- grant  out  N  one-hot current owner; 0 when idle.
- busy  out  1  high from ISSUE through ACK.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE.
  - ack, grant, busy, mem_en, mem_we = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - Priority pointer = 0, so requester 0 has highest priority after reset.
- States: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
- IDLE:
  - If any req bit is set, select the winner by round-robin: scan from the pointer upward, modulo N.
  - Latch the winner's addr, we and wdata into mem_addr, mem_we, mem_wdata.
  - Set grant to the winner, assert mem_en and busy, go to ISSUE.
  - If no req bit is set, stay in IDLE with all strobes low.
- ISSUE (1 cycle):
  - mem_en = 1.
  - Load the latency counter with MEM_LAT-1, go to WAIT.
  - On exit, mem_en drops to 0; mem_addr and mem_we hold their values.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, capture rdata: mem_rdata for a read, 0 for a write. Go to ACK.
  - The capture cycle is exactly MEM_LAT cycles after the ISSUE cycle.
- ACK (1 cycle):
  - ack = grant.
  - Pointer = (winner+1) mod N.
  - Next cycle: grant = 0, busy = 0, ack = 0, rdata cleared to 0, state = IDLE.
- Latency: req sampled in IDLE at cycle k -> mem_en in cycle k+1 -> ack in cycle k+2+MEM_LAT. Next arbitration is at cycle k+3+MEM_LAT.
- Requester duty: drop req (or present a new request) in the cycle after ack. A req still high in the IDLE cycle after ack is treated as a new request.
- A req dropped mid-transaction is ignored: the access completes and ack still pulses.
- Changes to addr, we or wdata after the IDLE grant cycle have no effect on the current access.
- Simultaneous requests: only one winner; the losers keep waiting. Pointer rotation guarantees a waiting requester is served within N transactions.
- Single requester: served repeatedly; pointer rotation does not add delay.
- Reset asserted in any state takes effect at the next edge. It aborts the transaction without an ack, returns all outputs to reset values, and sets the pointer to 0.
- No combinational path from req to any output.

Test Plan:
- Single read: N=2, MEM_LAT=2, req[0]=1 we=0 addr=0x10, memory returns 0xDEADBEEF -> mem_en high only in cycle 1 with mem_addr=0x10; ack=2'b01 in cycle 4 with rdata=0xDEADBEEF.
- Write: req[1]=1 we=1 addr=0x20 wdata=0x12345678 -> mem_en=1, mem_we=1, mem_wdata=0x12345678 for one cycle; ack=2'b10 four cycles after the request; rdata=0.
- Contention: req=2'b11 held from reset, each drops req after its ack then re-requests -> grant order 0,1,0,1; no two acks closer than MEM_LAT+3 cycles.
- Fairness with N=4: requester 0 requests continuously, requester 3 raises req -> requester 3 acked within at most 2 transactions.
- Reset mid-op: assert reset during WAIT -> next cycle all outputs 0, no ack; then req[1] alone is granted normally; with req=2'b11, requester 0 wins first.
- Request withdrawal: req[0] dropped during WAIT -> ack[0] still pulses; the next IDLE grants requester 1 if it is requesting.
